// File: rtl/bram_word_bridge.sv
// bram_word_bridge: sequences word-wide load/store requests onto a byte-wide
// block RAM port with a one-cycle registered read latency.
// Optional build macro BRAM_BRIDGE_ALIGN_CHECK_EN: misaligned requests are
// answered with o_rsp_err = 1 and no RAM access; otherwise the low address
// bits are ignored and o_rsp_err is always 0.
module bram_word_bridge #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_write,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [8*WORD_BYTES-1:0] i_req_wdata,
  input  logic [WORD_BYTES-1:0]   i_req_be,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [8*WORD_BYTES-1:0] o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [7:0]              o_mem_wdata,
  output logic                    o_mem_write,
  input  logic [7:0]              i_mem_rdata
);

  localparam int unsigned LB = $clog2(WORD_BYTES);
  localparam int unsigned CW = LB + 1;
  localparam int unsigned DW = 8 * WORD_BYTES;
  localparam int unsigned BW = ADDR_WIDTH - LB;
  localparam logic [CW-1:0] LastCnt = CW'(WORD_BYTES);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StResp} state_e;

  state_e          state_q, state_d;
  // Counts edges since accept; byte k is captured when the count reaches k+2.
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            misal_q, misal_d;
  logic [WORD_BYTES-1:0] be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   base_q, base_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            mem_write_q, mem_write_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [LB-1:0]   lane, cap_lane;
  logic            misalign;

`ifdef BRAM_BRIDGE_ALIGN_CHECK_EN
  assign misalign = |i_req_addr[LB-1:0];
`else
  assign misalign = 1'b0;
  logic unused_low_addr;
  assign unused_low_addr = ^i_req_addr[LB-1:0];
`endif

  assign lane     = cnt_q[LB-1:0];
  assign cap_lane = cnt_q[LB-1:0] - LB'(2);

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    misal_d     = misal_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    base_d      = base_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = mem_write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          write_d   = i_req_write;
          be_d      = i_req_be;
          wdata_d   = i_req_wdata;
          base_d    = i_req_addr[ADDR_WIDTH-1:LB];
          rdata_d   = '0;
          rsp_err_d = 1'b0;
          misal_d   = misalign;
          cnt_d     = CW'(1);
          state_d   = StIssue;
          if (!misalign) begin
            mem_addr_d  = {i_req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            mem_wdata_d = i_req_wdata[7:0];
            mem_write_d = i_req_write & i_req_be[0];
          end
        end
      end
      StIssue: begin
        if (misal_q) begin
          // Misaligned: answer with an error, never touch the RAM.
          misal_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          if (!write_q && cnt_q >= CW'(2)) begin
            rdata_d[{cap_lane, 3'b000} +: 8] = i_mem_rdata;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastCnt) begin
            mem_write_d = 1'b0;
            if (write_q) begin
              rsp_valid_d = 1'b1;
              state_d     = StResp;
            end else begin
              state_d = StDrain;
            end
          end else begin
            mem_addr_d  = {base_q, lane};
            mem_wdata_d = wdata_q[{lane, 3'b000} +: 8];
            mem_write_d = write_q & be_q[lane];
          end
        end
      end
      StDrain: begin
        rdata_d[{cap_lane, 3'b000} +: 8] = i_mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      misal_q     <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      base_q      <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      misal_q     <= misal_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      base_q      <= base_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = (state_q == StIdle);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_write = mem_write_q;

endmodule

// File: tb/tb_bram_word_bridge.sv
// Testbench for bram_word_bridge: byte RAM model, word-level reference model
// checked every cycle, and directed requests with literal expectations.
module tb_bram_word_bridge;

  localparam int W = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;

  bram_word_bridge #(.ADDR_WIDTH(12), .WORD_BYTES(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_be    (req_be),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_write (mem_write),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Physical byte RAM with registered read.
  bit [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one outstanding word request, judged by edge count.
  bit [7:0]    ref_mem [0:4095];
  bit          m_busy = 1'b0;
  bit          m_write, m_err, ev;
  int          m_acc, m_rsp_edge, j;
  logic [11:0] m_base;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_rdata;
  bit          pend_v = 1'b0;
  logic [11:0] pend_a;
  logic [7:0]  pend_d;

  always @(negedge clk) begin
    if (pend_v) begin
      ref_mem[pend_a] = pend_d;
      pend_v = 1'b0;
    end
    if (!rst_n) begin
      m_busy = 1'b0;
      chk("rst_mem_write", mem_write, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end else if (!m_busy) begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_mem_write", mem_write, 0);
      if (req_valid) begin
        m_busy  = 1'b1;
        m_acc   = cyc + 1;
        m_write = req_write;
        m_base  = {req_addr[11:2], 2'b00};
        m_be    = req_be;
        m_wdata = req_wdata;
`ifdef BRAM_BRIDGE_ALIGN_CHECK_EN
        m_err = (req_addr[1:0] != 2'b00);
`else
        m_err = 1'b0;
`endif
        m_rsp_edge = m_acc + (m_err ? 1 : (m_write ? W : W + 1));
        m_rdata = '0;
        if (!m_write && !m_err)
          for (int b = 0; b < W; b++) m_rdata[8*b +: 8] = ref_mem[12'(m_base + b)];
      end
    end else begin
      j  = cyc - m_acc;
      ev = (cyc >= m_rsp_edge);
      chk("busy_req_ready", req_ready, 0);
      chk("rsp_valid", rsp_valid, ev);
      if (m_err) begin
        chk("err_mem_write", mem_write, 0);
      end else if (j < W) begin
        chk("mem_addr", mem_addr, 12'(m_base + j));
        chk("mem_write", mem_write, m_write & m_be[j]);
        if (m_write) chk("mem_wdata", mem_wdata, m_wdata[8*j +: 8]);
        if (m_write && m_be[j]) begin
          pend_v = 1'b1;
          pend_a = 12'(m_base + j);
          pend_d = m_wdata[8*j +: 8];
        end
      end else begin
        chk("tail_mem_write", mem_write, 0);
        chk("tail_mem_addr", mem_addr, 12'(m_base + W - 1));
      end
      if (ev) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        if (rsp_ready) m_busy = 1'b0;
      end
    end
  end

  // One request from an idle bridge through its response handshake.
  task automatic do_req(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit early, input int hold,
                        output logic [31:0] rd, output int lat);
    int k;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    rsp_ready = early;
    rd  = '0;
    lat = 0;
    k   = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready && k < 20);
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", rsp_valid, 1);
      rsp_ready = 1'b0;
      return;
    end
    rd = rsp_rdata;
    if (!early) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, rd);
        chk("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("post_hs_req_ready", req_ready, 1);
    chk("post_hs_rsp_valid", rsp_valid, 0);
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word store then load back.
    do_req(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 0, rd, lat);
    chk("st_lat", lat, 4);
    chk("st_rdata", rd, 0);
    chk("ram_010", ram[12'h010], 8'hEF);
    chk("ram_011", ram[12'h011], 8'hBE);
    chk("ram_012", ram[12'h012], 8'hAD);
    chk("ram_013", ram[12'h013], 8'hDE);
    do_req(1'b0, 12'h010, 32'h0, 4'h0, 1'b1, 0, rd, lat);
    chk("ld_lat", lat, 5);
    chk("ld_rdata", rd, 32'hDEADBEEF);

    // Partial byte enables.
    do_req(1'b1, 12'h010, 32'h11223344, 4'h5, 1'b0, 0, rd, lat);
    chk("ram_010_be", ram[12'h010], 8'h44);
    chk("ram_011_be", ram[12'h011], 8'hBE);
    chk("ram_012_be", ram[12'h012], 8'h22);
    do_req(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 0, rd, lat);
    chk("ld_be_rdata", rd, 32'hDE22BE44);

    // Misaligned load address.
    do_req(1'b0, 12'h013, 32'h0, 4'h0, 1'b0, 0, rd, lat);
`ifdef BRAM_BRIDGE_ALIGN_CHECK_EN
    chk("misal_lat", lat, 1);
    chk("misal_rdata", rd, 0);
`else
    chk("misal_lat", lat, 5);
    chk("misal_rdata", rd, 32'hDE22BE44);
`endif

    // Top word with a stalled response.
    do_req(1'b1, 12'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, 0, rd, lat);
    do_req(1'b0, 12'hFFC, 32'h0, 4'h0, 1'b0, 6, rd, lat);
    chk("top_rdata", rd, 32'hCAFEF00D);
    chk("top_lat", lat, 5);

    // Store with no enabled lanes.
    do_req(1'b1, 12'h030, 32'hFFFFFFFF, 4'h0, 1'b0, 0, rd, lat);
    chk("be0_lat", lat, 4);
    chk("be0_ram_030", ram[12'h030], 8'h00);
    chk("be0_ram_033", ram[12'h033], 8'h00);

    // Reset during a store, after two bytes reached the RAM.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h020;
    req_wdata = 32'hA1B2C3D4;
    req_be    = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_no_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("abort_ram_022", ram[12'h022], 8'h00);
    do_req(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 0, rd, lat);
    chk("abort_ld_rdata", rd, 32'h0000C3D4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
